// File: rtl/cla_seq_mul.sv
// Sequential shift-and-add unsigned multiplier built around a single 32-bit
// carry-lookahead adder. One partial product is accumulated per clock, so a
// multiply takes a fixed BW_OP+2 cycles from start to start.

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c,
    output logic [31:0] o_s,
    output logic        o_c
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // Generate/propagate terms and lookahead carries inside each 4-bit group.
    always_comb begin
        g = i_a & i_b;
        p = i_a ^ i_b;
        c = '0;
        c[0] = i_c;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        o_s = p ^ c[31:0];
        o_c = c[32];
    end
endmodule

// Handshake: i_start is sampled only in IDLE; the operands are captured on
// that same edge. o_busy stays high from the next cycle through the DONE
// cycle. o_done is a single-cycle pulse in which o_p first shows the new
// product; o_p then holds until the next o_done. Starts outside IDLE are
// dropped, so a held-high i_start yields one multiply every BW_OP+2 cycles.
module cla_seq_mul #(
    parameter int BW_OP = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [BW_OP-1:0] i_a,
    input  logic [BW_OP-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_p,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(BW_OP - 1);

    state_t           state;
    state_t           state_next;
    logic [31:0]      mc;
    logic [BW_OP-1:0] mr;
    logic [31:0]      acc;
    logic [4:0]       cnt;
    logic [31:0]      sum;
    logic [31:0]      acc_step;
    logic             last_iter;
    // Carry out of acc+mc is structurally zero while accumulating: the partial
    // sum never exceeds 2^(2*BW_OP)-1, so the datapath ignores it.
    logic             unused_carry;

    cla u_cla (
        .i_a (acc),
        .i_b (mc),
        .i_c (1'b0),
        .o_s (sum),
        .o_c (unused_carry)
    );

    // Accumulator value after this iteration's conditional add.
    always_comb begin
        acc_step  = mr[0] ? sum : acc;
        last_iter = (cnt == LAST_CNT);
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed BW_OP iterations, then one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_busy    = (state == BUSY) || (state == DONE);
        o_done    = (state == DONE);
        dbg_state = state;
    end

    // Datapath: operand capture in IDLE, shift-and-add in BUSY.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mc  <= '0;
            mr  <= '0;
            acc <= '0;
            cnt <= '0;
            o_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        mc  <= 32'(i_a);
                        mr  <= i_b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    mc  <= mc << 1;
                    mr  <= mr >> 1;
                    cnt <= cnt + 5'd1;
                    if (last_iter) begin
                        o_p <= acc_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/cla_seq_mul.md
CLA_SEQ_MUL -- requirements
Module: cla_seq_mul

Interface
REQ-001 The block SHALL have parameter BW_OP, default 16, giving the operand width; legal range 2..16, so the 2*BW_OP product fits the 32-bit CLA datapath.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_start, input, 1 bit: request to start a multiply.
REQ-005 The block SHALL have port i_a, input, BW_OP bits: multiplicand, unsigned.
REQ-006 The block SHALL have port i_b, input, BW_OP bits: multiplier, unsigned.
REQ-007 The block SHALL have port o_busy, output, 1 bit: high while a multiply is in progress, i.e. in states BUSY and DONE.
REQ-008 The block SHALL have port o_done, output, 1 bit: one-cycle pulse marking o_p valid with a new product.
REQ-009 The block SHALL have port o_p, output, 32 bits: product, zero-extended above 2*BW_OP.

Function
REQ-010 The block SHALL instantiate one CLA (32-bit i_a/i_b/i_c, o_s/o_c) as its only adder, with i_c tied to 0.
REQ-011 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-012 In IDLE with i_start=1 at an edge, the block SHALL capture the following and enter BUSY:
- i_a zero-extended to 32 bits into the multiplicand register mc
- i_b into shift register mr
- 0 into accumulator acc
- 0 into iteration counter cnt
REQ-013 In IDLE with i_start=0, the block SHALL hold all registers.
REQ-014 On each BUSY edge, the block SHALL update its registers as follows:
- acc <= CLA.o_s (acc + mc) if mr[0]=1, else acc unchanged
- mc <= mc << 1
- mr <= mr >> 1
- cnt <= cnt + 1
REQ-015 The block SHALL leave BUSY for DONE on the edge that completes iteration BW_OP (cnt = BW_OP-1), loading o_p with the final acc value (including that iteration's add) on the same edge.
REQ-016 The block SHALL assert o_done=1 during exactly the single DONE cycle, then return to IDLE on the next edge.
REQ-017 Latency SHALL be fixed: o_done is high in the cycle following edge BW_OP+1 after i_start is sampled (default 17 edges), independent of operand values; there SHALL be no early termination.
REQ-018 The block SHALL ignore i_start in BUSY and DONE; the in-flight operation SHALL be unaffected, and a new start is accepted only in IDLE.
REQ-019 The minimum start-to-start spacing SHALL be BW_OP+2 cycles; a start held high continuously SHALL produce back-to-back operations at that rate.
REQ-020 The block SHALL hold o_p stable between o_done pulses, with the last product remaining visible in IDLE.
REQ-021 i_a and i_b SHALL be don't-care outside the start-sample edge; operand changes during BUSY SHALL NOT affect the result.
REQ-022 CLA.o_c SHALL be 0 on every accumulate, since the partial sum is bounded by 2^(2*BW_OP)-1; the block SHALL leave o_c unused in the datapath.

Reset
REQ-023 While i_rst=1, the block SHALL immediately, without a clock edge, force:
- state=IDLE
- acc, mc, mr, cnt = 0
- o_p=0, o_done=0, o_busy=0
REQ-024 On reset mid-operation, the block SHALL abort the operation with no o_done pulse; o_p SHALL read 0 after reset.
REQ-025 The first edge after i_rst falls SHALL be treated as a normal IDLE edge, so i_start=1 on that edge starts an operation.

Verification
REQ-026 Directed scenario, basic: a=3, b=5, start one cycle -> o_busy high next cycle, o_done pulse exactly 17 edges after start, o_p=0x0000000F, o_busy low after DONE.
REQ-027 Directed scenario, max: a=0xFFFF, b=0xFFFF -> o_p=0xFFFE0001; CLA o_c=0 on every iteration (bench asserts).
REQ-028 Directed scenario, zero: a=0x1234, b=0 and a=0, b=0xFFFF -> o_p=0 in both cases, with the same 17-edge latency as non-zero operands.
REQ-029 Directed scenario, start ignored: start a=2, b=7; pulse i_start with a=9, b=9 at cycle 5 -> single o_done, o_p=0x0000000E; no second operation.
REQ-030 Directed scenario, reset mid-op: a=0x00FF, b=0x0101, assert i_rst at cycle 8 -> outputs zero immediately, no o_done; after release, a=6, b=7 -> o_p=0x0000002A.
REQ-031 Directed scenario, back-to-back: i_start held high with a fixed operand pair -> o_done every 18 cycles, o_p correct each time; a further 1000 random vectors SHALL be checked against a*b.
